// File: rtl/swipt_pkg.sv
// Shared definitions for the SWIPT serial link (transmitter and analyser):
// frame-state encoding, default timing constants and the ones-count helper.
package swipt_pkg;

    // Frame-sequencer states; CHECK is only entered when the checksum trailer is built in.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_GUARD = 3'd4
    } swipt_state_e;

    // Clocks per transmitted bit on the real link.
    localparam int BIT_PERIOD_DEF   = 200000;
    // Half a bit period: where the analyser takes its first sample after the start edge.
    localparam int FIRST_SAMPLE_OFS = 100000;
    // Payload bits per frame.
    localparam int FRAME_BITS_DEF   = 36;
    // Program code that enables transmission.
    localparam logic [1:0] PROG_TX  = 2'b11;

    // Number of set bits in a word of up to 64 bits; the result never exceeds 64.
    function automatic logic [7:0] popcount64(input logic [63:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/swipt_bit_timer.sv
// Bit-period timer shared by the SWIPT transmitter and analyser.
// Counts 0..BIT_PERIOD-1 while enabled and flags the last clock of each bit.
module swipt_bit_timer #(
    parameter int BIT_PERIOD = 200000,
    parameter int CNT_W      = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrap at the bit boundary so every bit lasts exactly BIT_PERIOD clocks.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Period counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/swipt_frame_tx.sv
// SWIPT serial frame transmitter: start bit, MSB-first payload, optional
// ones-count trailer, then one low guard bit. All outputs are registered.
// Build option: define SWIPT_TX_CHECKSUM_EN to append the 8-bit ones-count trailer.
module swipt_frame_tx
    import swipt_pkg::*;
#(
    parameter int BIT_PERIOD = BIT_PERIOD_DEF,
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int CNT_W      = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  swiptAlive_i,
    input  logic [1:0]            program_i,
    input  logic                  txStart_i,
    input  logic [FRAME_BITS-1:0] txData_i,
    output logic                  dout_o,
    output logic                  txBusy_o,
    output logic                  txDone_o,
    output logic [7:0]            onesCount_o
);

    // Bit counter must index every payload bit and the 8 trailer bits.
    localparam int BC_W = (FRAME_BITS > 8) ? $clog2(FRAME_BITS) : 3;
    localparam logic [BC_W-1:0] LAST_DATA = BC_W'(FRAME_BITS - 1);

    logic                  enable;
    logic                  tick;
    logic                  timerEn;
    logic                  timerClr;
    swipt_state_e          state_q,     state_d;
    logic [FRAME_BITS-1:0] sr_q,        sr_d;
    logic [BC_W-1:0]       bitCnt_q,    bitCnt_d;
    logic [7:0]            onesCount_q, onesCount_d;
    logic                  dout_q,      dout_d;
    logic                  txBusy_q,    txBusy_d;
    logic                  txDone_q,    txDone_d;
`ifdef SWIPT_TX_CHECKSUM_EN
    logic [2:0]            chkIdx;
`endif

    assign enable = swiptAlive_i && (program_i == PROG_TX);

    // The timer runs only inside a frame and is held at zero in IDLE, so the
    // start bit begins a full period on the cycle after accept.
    assign timerEn  = (state_q != ST_IDLE);
    assign timerClr = (state_q == ST_IDLE) || !enable;

    swipt_bit_timer #(
        .BIT_PERIOD (BIT_PERIOD),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .en_i   (timerEn),
        .clr_i  (timerClr),
        .tick_o (tick)
    );

    // Frame sequencer: advances one bit per timer tick; losing enable aborts to IDLE.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bitCnt_d    = bitCnt_q;
        onesCount_d = onesCount_q;
        txDone_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (txStart_i && enable) begin
                    sr_d        = txData_i;
                    onesCount_d = popcount64(64'(txData_i));
                    bitCnt_d    = '0;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bitCnt_q == LAST_DATA) begin
                        bitCnt_d = '0;
`ifdef SWIPT_TX_CHECKSUM_EN
                        state_d  = ST_CHECK;
`else
                        state_d  = ST_GUARD;
`endif
                    end else begin
                        sr_d     = {sr_q[FRAME_BITS-2:0], 1'b0};
                        bitCnt_d = bitCnt_q + 1'b1;
                    end
                end
            end
`ifdef SWIPT_TX_CHECKSUM_EN
            ST_CHECK: begin
                if (tick) begin
                    if (bitCnt_q == BC_W'(7)) begin
                        bitCnt_d = '0;
                        state_d  = ST_GUARD;
                    end else begin
                        bitCnt_d = bitCnt_q + 1'b1;
                    end
                end
            end
`endif
            ST_GUARD: begin
                if (tick) begin
                    state_d  = ST_IDLE;
                    txDone_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if ((state_q != ST_IDLE) && !enable) begin
            state_d  = ST_IDLE;
            bitCnt_d = '0;
            txDone_d = 1'b0;
        end
    end

`ifdef SWIPT_TX_CHECKSUM_EN
    assign chkIdx = 3'd7 - bitCnt_d[2:0];
`endif

    // Line level is decoded from the next state so dout is a plain register.
    always_comb begin
        dout_d = 1'b0;
        case (state_d)
            ST_START: dout_d = 1'b1;
            ST_DATA:  dout_d = sr_d[FRAME_BITS-1];
`ifdef SWIPT_TX_CHECKSUM_EN
            ST_CHECK: dout_d = onesCount_q[chkIdx];
`endif
            default:  dout_d = 1'b0;
        endcase
        txBusy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            bitCnt_q    <= '0;
            onesCount_q <= '0;
            dout_q      <= 1'b0;
            txBusy_q    <= 1'b0;
            txDone_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bitCnt_q    <= bitCnt_d;
            onesCount_q <= onesCount_d;
            dout_q      <= dout_d;
            txBusy_q    <= txBusy_d;
            txDone_q    <= txDone_d;
        end
    end

    assign dout_o      = dout_q;
    assign txBusy_o    = txBusy_q;
    assign txDone_o    = txDone_q;
    assign onesCount_o = onesCount_q;

endmodule

// File: tb/tb_swipt_frame_tx.sv
// Directed bench for swipt_frame_tx with BIT_PERIOD=4, FRAME_BITS=36.
// Expectations follow SWIPT_TX_CHECKSUM_EN the same way the design does.
module tb_swipt_frame_tx;

    localparam int BP = 4;
    localparam int FB = 36;
`ifdef SWIPT_TX_CHECKSUM_EN
    localparam int NBITS = 1 + FB + 8 + 1;
`else
    localparam int NBITS = 2 + FB;
`endif
    localparam int FRAME_CYC = NBITS * BP;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          swiptAlive = 1'b1;
    logic [1:0]    prog = 2'b11;
    logic          txStart = 1'b0;
    logic [FB-1:0] txData = '0;
    logic          dout;
    logic          txBusy;
    logic          txDone;
    logic [7:0]    onesCount;

    int n_pass  = 0;
    int n_total = 0;

    swipt_frame_tx #(
        .BIT_PERIOD (BP),
        .FRAME_BITS (FB),
        .CNT_W      (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .swiptAlive_i (swiptAlive),
        .program_i    (prog),
        .txStart_i    (txStart),
        .txData_i     (txData),
        .dout_o       (dout),
        .txBusy_o     (txBusy),
        .txDone_o     (txDone),
        .onesCount_o  (onesCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FB-1:0] data;
        logic [7:0]    ones;
        int            poke;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Line level expected during frame bit b (0 = start bit).
    function automatic logic exp_bit(input logic [FB-1:0] d, input logic [7:0] ones, input int b);
        if (b == 0) return 1'b1;
        if (b <= FB) return d[6'(FB - b)];
`ifdef SWIPT_TX_CHECKSUM_EN
        if (b <= FB + 8) return ones[3'(FB + 8 - b)];
`endif
        return 1'b0;
    endfunction

    // Send one frame and check every cycle of it; optionally pulse txStart at cycle poke.
    task automatic run_frame(input logic [FB-1:0] d, input logic [7:0] ones, input int poke);
        txData  = d;
        txStart = 1'b1;
        step();
        txStart = 1'b0;
        for (int c = 0; c < FRAME_CYC; c++) begin
            chk("dout", 64'(dout), 64'(exp_bit(d, ones, c / BP)));
            chk("busy_done", 64'({txBusy, txDone}), 64'(2'b10));
            txStart = (c == poke);
            if (c == poke) txData = ~d;
            step();
        end
        txStart = 1'b0;
        chk("done_cycle", 64'({dout, txBusy, txDone}), 64'(3'b001));
        chk("onesCount", 64'(onesCount), 64'(ones));
        step();
        for (int k = 0; k < 6; k++) begin
            chk("idle_after", 64'({dout, txBusy, txDone}), 64'(3'b000));
            step();
        end
    endtask

    initial begin
        vecs[0] = '{data: 36'h8_0000_0001, ones: 8'd2,  poke: -1};
        vecs[1] = '{data: 36'hF_FFFF_FFFF, ones: 8'd36, poke: -1};
        vecs[2] = '{data: 36'hA_5A5A_5A5A, ones: 8'd18, poke: -1};
        vecs[3] = '{data: 36'h1_2345_6789, ones: 8'd15, poke: 60};
        vecs[4] = '{data: 36'h0_0000_0000, ones: 8'd0,  poke: -1};

        // Reset state
        step();
        step();
        rst = 1'b0;
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_busy", 64'(txBusy), 64'd0);
        chk("rst_done", 64'(txDone), 64'd0);
        chk("rst_ones", 64'(onesCount), 64'd0);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].data, vecs[i].ones, vecs[i].poke);
        end

        // Gating: wrong program code, then link not alive
        prog = 2'b01;
        txData = 36'h8_0000_0001;
        txStart = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("gate_prog", 64'({dout, txBusy, txDone}), 64'(3'b000));
        end
        prog = 2'b11;
        swiptAlive = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("gate_alive", 64'({dout, txBusy, txDone}), 64'(3'b000));
        end
        txStart = 1'b0;
        swiptAlive = 1'b1;
        step();

        // Abort during DATA bit 10 (cycles 44..47 of the frame)
        txData = 36'hF_FFFF_FFFF;
        txStart = 1'b1;
        step();
        txStart = 1'b0;
        for (int k = 0; k < 45; k++) step();
        chk("pre_abort_busy", 64'(txBusy), 64'd1);
        swiptAlive = 1'b0;
        step();
        chk("abort_out", 64'({dout, txBusy, txDone}), 64'(3'b000));
        chk("abort_ones_held", 64'(onesCount), 64'd36);
        swiptAlive = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("abort_quiet", 64'({dout, txBusy, txDone}), 64'(3'b000));
        end
        run_frame(36'h8_0000_0001, 8'd2, -1);

        // Back-to-back with txStart held high
        begin
            logic [3:0] hist;
            bit found;
            hist = 4'hF;
            found = 1'b0;
            txData = 36'h8_0000_0001;
            txStart = 1'b1;
            for (int k = 0; k < 400 && !found; k++) begin
                step();
                if (txDone) found = 1'b1;
                else hist = {hist[2:0], dout};
            end
            chk("b2b_done_seen", 64'(found), 64'd1);
            chk("b2b_guard_low", 64'({hist, dout, txBusy}), 64'd0);
            step();
            chk("b2b_restart", 64'({dout, txBusy, txDone}), 64'(3'b110));
            txStart = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 400 && !found; k++) begin
                step();
                if (txDone) found = 1'b1;
            end
            chk("b2b_second_done", 64'(found), 64'd1);
            step();
        end

        // Reset mid-frame (cycle 150 lies in CHECK, or GUARD without the trailer)
        txData = 36'hF_FFFF_FFFF;
        txStart = 1'b1;
        step();
        txStart = 1'b0;
        for (int k = 0; k < 150; k++) step();
        chk("pre_rst_busy", 64'(txBusy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_out", 64'({dout, txBusy, txDone}), 64'(3'b000));
        chk("midrst_ones", 64'(onesCount), 64'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("midrst_quiet", 64'({dout, txBusy, txDone}), 64'(3'b000));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/swipt_frame_tx.md
# swipt_frame_tx

- Serial frame transmitter for the SWIPT data link; the transmit-side counterpart of the frame analyser.
- Latches a parallel payload word and drives it onto the single-wire `dout` line, MSB first, at one bit per `BIT_PERIOD` clocks.
- Prefixes a high start bit so the far end can detect a rising edge; optionally appends a ones-count checksum byte.
- Sits between the controller that builds mode/type/data words and the modulation driver.

## Interface
- `BIT_PERIOD`, 200000: clocks per transmitted bit (≥2)
- `FRAME_BITS`, 36: payload bits per frame
- `CNT_W`, 20: bit-period counter width; must hold `BIT_PERIOD-1`
- `clk` in 1: system clock
- `rst` in 1: reset, synchronous, active-high
- `swiptAlive` in 1: link powered; low aborts
- `program` in 2: transmit enabled only when `2'b11`
- `txStart` in 1: request to send `txData`; sampled only in IDLE
- `txData` in FRAME_BITS: payload, MSB sent first
- `dout` out 1: serial line, idle low
- `txBusy` out 1: high from accept until the end of GUARD
- `txDone` out 1: one-cycle pulse at frame completion
- `onesCount` out 8: ones count of the latched payload, valid from the accept cycle +1

## Operation
- `enable = swiptAlive && program == 2'b11`.
- States: IDLE, START, DATA, CHECK, GUARD.
- IDLE:
  - `dout = 0`.
  - On `txStart && enable`, latch `txData` into the shift register, load `onesCount = popcount(txData)` (8-bit, max 36, no overflow), clear `bitCnt`, go to START.
- START: `dout = 1` for `BIT_PERIOD` clocks, then go to DATA.
- DATA:
  - `dout` = shift register MSB.
  - Each `BIT_PERIOD` clocks, shift left by one and increment `bitCnt`.
  - After bit `FRAME_BITS-1`, go to CHECK (or GUARD when the macro is off).
- CHECK: send `onesCount[7:0]` MSB first, 8 bits of `BIT_PERIOD` clocks each, then go to GUARD.
- GUARD:
  - `dout = 0` for `BIT_PERIOD` clocks, so that back-to-back frames produce a fresh rising edge.
  - Then pulse `txDone` and return to IDLE.
- Counter: `periodCnt` counts 0..`BIT_PERIOD-1`. A bit boundary is `periodCnt == BIT_PERIOD-1`, which clears the counter.
- Abort:
  - Deasserting `enable` in any non-IDLE state forces IDLE next cycle, with `dout = 0`, `txBusy = 0`, and no `txDone`.
  - `onesCount` keeps its last value.
- `txStart` outside IDLE is ignored, not queued.
- `txStart` together with `!enable` is ignored.

## Timing
- Reset values: `dout = 0`, `txBusy = 0`, `txDone = 0`, `onesCount = 0`, state = IDLE, counters cleared.
- Accept at edge N: `dout` and `txBusy` go high at N+1.
- Every bit, including the start bit, occupies exactly `BIT_PERIOD` cycles.
- Frame length in cycles: `(1 + FRAME_BITS + 8 + 1) × BIT_PERIOD` with the checksum; `(2 + FRAME_BITS) × BIT_PERIOD` without it.
- `txDone` is high in the cycle `txBusy` falls.
- A new `txStart` is accepted in the cycle after `txDone`.
- All outputs are registered; there is no combinational path from inputs to `dout`.
- `rst` mid-frame: next cycle equals the reset state.
- An abort by `enable` mid-frame behaves the same, except that `onesCount` is held.

## Configuration
- Macro: `SWIPT_TX_CHECKSUM_EN`.
- Defined: the CHECK state exists and the 8-bit ones-count trailer is sent after the payload.
- Undefined:
  - CHECK is removed; DATA goes directly to GUARD.
  - `onesCount` is still computed and output.

## Structure
- Shared package `swipt_pkg` holds:
  - the state enum (IDLE/START/DATA/CHECK/GUARD);
  - the `BIT_PERIOD` default of 200000;
  - the first-sample offset constant of 100000;
  - `FRAME_BITS` = 36 and the program code `2'b11`.
- One sub-module, `swipt_bit_timer`: the period counter with a `tick` output and a synchronous clear, so the analyser can reuse it.
- Popcount is a combinational function in the package.

## Test plan
All scenarios use `BIT_PERIOD=4` and `FRAME_BITS=36` in simulation.
- Basic frame, macro on: `txData=36'h8_0000_0001`, `enable=1`, pulse `txStart` → `dout` is 4 cycles high (start), then `1`, 34×`0`, `1` (4 cycles each), then checksum `8'h02` MSB first, then 4 low; `txDone` at cycle 184 after accept; `onesCount=2`.
- All-ones payload: `txData=36'hF_FFFF_FFFF` → `onesCount=36`, trailer `00100100`.
- Macro off: same stimulus as the basic frame → no trailer; `txDone` at cycle 152; GUARD follows the last data bit directly.
- Abort: drop `swiptAlive` during DATA bit 10 → next cycle `dout=0` and `txBusy=0`, no `txDone`; a later `txStart` sends a full fresh frame.
- Gating and ignore:
  - `program=2'b01` with `txStart` → no activity.
  - `txStart` pulsed during DATA → ignored; exactly one frame is sent.
- Back-to-back: hold `txStart` high continuously → second start bit rises 1 cycle after `txDone`, preceded by 4 low GUARD cycles.
- Reset mid-frame: `rst` asserted during CHECK → all outputs at reset values next cycle, including `onesCount=0`.
